uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin controller that shares the single UART byte transmitter between up to NUM_REQ on-chip requesters, such as the score, paddle and ball-state reporters. It accepts one byte at a time from the winning requester and pulses the transmitter's start. It then tracks the transmitter's busy handshake to completion and enforces a minimum idle gap before the next grant. It sits between the game logic and the transmitter that drives the TX pin.

## Interface

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: width of grant_id; must equal clog2(NUM_REQ).
- GAP_CYCLES, 217: idle clocks inserted after each byte completes (one bit time at 115200 baud / 25 MHz); 0 = no gap.
- WAIT_CYCLES, 1023: maximum clocks to wait for tx_busy to rise after a start; max 4095.

Ports:
- clock, in, 1: sole clock; all logic on rising edge.
- reset, in, 1: asynchronous, active-high.
- req, in, NUM_REQ: per-requester byte-valid level; held until the matching ack.
- req_data, in, 8*NUM_REQ: byte for requester i on bits [8i+7:8i]; held stable while req[i]=1.
- ack, out, NUM_REQ: one-cycle pulse; byte of requester i latched.
- tx_start, out, 1: one-cycle start pulse to the transmitter.
- tx_data, out, 8: registered byte to the transmitter; stable from the tx_start cycle until the next grant.
- tx_busy, in, 1: transmitter busy level.
- grant_id, out, ID_W: index of the current or last granted requester.
- active, out, 1: high in every state except IDLE.
- timeout_err, out, 1: one-cycle pulse; tx_busy never rose within WAIT_CYCLES.

## Operation

- States: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE → START when at least one req bit is 1 and tx_busy=0.
  - If tx_busy=1 in IDLE, no grant is made; stay in IDLE.
  - On this transition: latch the winner's byte into tx_data, set grant_id, register ack[winner].
- Round-robin:
  - Search starts at (last+1) mod NUM_REQ and wraps; first set req bit wins.
  - last is updated to the winner.
  - Reset value of last is NUM_REQ-1, so requester 0 has top priority after reset.
- START: tx_start=1 and ack[winner]=1 for exactly this cycle. START → WAIT_BUSY unconditionally; the wait counter clears.
- WAIT_BUSY:
  - tx_busy=1 → WAIT_DONE.
  - Else the counter increments. When it reaches WAIT_CYCLES-1 with tx_busy still 0: pulse timeout_err and go to GAP.
- WAIT_DONE: tx_busy=0 → GAP; the gap counter clears.
- GAP:
  - Count GAP_CYCLES clocks, then go to IDLE.
  - With GAP_CYCLES=0, WAIT_DONE goes directly to IDLE.
- A req still high in the ack cycle is treated as a new byte, eligible at the next IDLE.
- Deasserting req[i] before ack is allowed. If it happens after the grant decision, the latched byte is still sent.
- Counters are 12 bits. No wrap occurs within the parameter limits.

## Timing

- Reset values: state=IDLE, ack=0, tx_start=0, tx_data=0, grant_id=0, active=0, timeout_err=0, last=NUM_REQ-1, counters=0.
- Reset mid-operation aborts immediately. No start or ack is issued after reset release until a fresh IDLE grant.
- Grant latency: req sampled high in IDLE at edge T → ack and tx_start high in cycle T+1 → WAIT_BUSY from T+2.
- tx_busy is sampled each clock.
  - A busy pulse as short as 1 cycle is detected.
  - tx_busy already 1 in the first WAIT_BUSY cycle is accepted.
- Byte-to-byte spacing: next tx_start no earlier than GAP_CYCLES+2 clocks after tx_busy is seen falling.
- Timeout: timeout_err fires in the WAIT_CYCLES-th WAIT_BUSY cycle; GAP then follows as normal.
- At most one ack bit and one tx_start per transaction. ack and tx_start are always coincident.
- active is 1 from the START cycle through the last GAP cycle.

## Test plan

- Reset, then req=4'b0001, req_data[7:0]=8'hA5; a busy model raises tx_busy 3 cycles after start for 10 cycles:
  - ack[0] and tx_start in the same cycle, tx_data=8'hA5.
  - Next IDLE exactly GAP_CYCLES+1 cycles after tx_busy falls.
- req=4'b1111 held with data 8'h10..8'h13:
  - Grants in order 0,1,2,3,0; grant_id matches; tx_data follows each requester's byte.
- tx_busy tied 0, WAIT_CYCLES=8:
  - timeout_err pulses once, 8 cycles into WAIT_BUSY; returns to IDLE after the gap; no second ack for the same request.
- tx_busy held 1 while req=4'b0010:
  - No ack until tx_busy drops; grant within 1 cycle of the drop.
- Assert reset during WAIT_DONE:
  - All outputs 0 asynchronously.
  - After release with req=4'b1000, requester 3 is granted with no stale tx_start.
- GAP_CYCLES=0, requester 2 streaming bytes:
  - tx_start 2 cycles after each busy fall; ack[2] pulses once per byte.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART byte transmitter between NUM_REQ requesters.
// Latency: req sampled in IDLE at edge T -> ack/tx_start in cycle T+1; then busy handshake and idle gap.
// Backpressure: requesters hold req until ack; no grant while tx_busy is high or a byte is in flight.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int GAP_CYCLES  = 217,
    parameter int WAIT_CYCLES = 1023
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 active,
    output logic                 timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    // Timeout is decided on the edge where the wait counter would reach WAIT_CYCLES-1.
    localparam logic [11:0] WAIT_LAST = 12'((WAIT_CYCLES >= 2) ? WAIT_CYCLES - 2 : 0);
    localparam logic [11:0] GAP_LAST  = 12'((GAP_CYCLES >= 1) ? GAP_CYCLES - 1 : 0);

    state_t              state;
    logic [ID_W-1:0]     last;
    logic [11:0]         wait_cnt;
    logic [11:0]         gap_cnt;

    logic                win_vld;
    logic [ID_W-1:0]     win_id;
    logic                hi_vld;
    logic [ID_W-1:0]     hi_id;
    logic [ID_W-1:0]     lo_id;
    logic [7:0]          win_dat;
    logic [NUM_REQ-1:0]  win_onehot;

    // Lowest set req above last wins, otherwise wrap to the lowest set req overall.
    always_comb begin
        win_vld = 1'b0;
        hi_vld  = 1'b0;
        hi_id   = '0;
        lo_id   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_vld = 1'b1;
                lo_id   = ID_W'(i);
            end
            if (req[i] && (i > int'(last))) begin
                hi_vld = 1'b1;
                hi_id  = ID_W'(i);
            end
        end
        win_id = hi_vld ? hi_id : lo_id;
    end

    always_comb begin
        win_dat    = '0;
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_dat       = req_data[8*i +: 8];
                win_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            last        <= ID_W'(NUM_REQ - 1);
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            ack         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            active      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ack         <= '0;
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_vld && !tx_busy) begin
                        state    <= S_START;
                        ack      <= win_onehot;
                        tx_start <= 1'b1;
                        tx_data  <= win_dat;
                        grant_id <= win_id;
                        last     <= win_id;
                        active   <= 1'b1;
                    end
                end
                S_START: begin
                    state    <= S_WAIT_BUSY;
                    wait_cnt <= '0;
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (wait_cnt >= WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        gap_cnt     <= '0;
                        if (GAP_CYCLES == 0) begin
                            state  <= S_IDLE;
                            active <= 1'b0;
                        end else begin
                            state <= S_GAP;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 12'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        gap_cnt <= '0;
                        if (GAP_CYCLES == 0) begin
                            state  <= S_IDLE;
                            active <= 1'b0;
                        end else begin
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt >= GAP_LAST) begin
                        state  <= S_IDLE;
                        active <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 12'd1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule
